control_sequencer: RTL
======================

// Module: control_sequencer
// PURPOSE
//  Moore control unit that generates per-step datapath strobes, including Gra/Grb/Grc/Rin/Rout/BAout
//  for the register select/encode logic, from the IR opcode. It is the producer of those strobes.
//  Steps: fetch (T0-T2), then execute (T3-T7) for a subset of the ISA. Memory accesses use a ready handshake.
// PARAMETERS
//  OPW  5  opcode width, taken from ir[31:27]
// PORTS
//  clk        in   1   system clock; all state changes on rising edge
//  clr        in   1   asynchronous, active-high reset
//  ir         in   32  IR register contents; opcode = ir[31:27]; valid from T3 onward
//  mem_ready  in   1   memory done; sampled on clk edge while Read or Write is high
//  PCout,IncPC,PCin,MARin,MDRin,MDRout,IRin,Yin,Zin,Zlowout,Cout  out 1  datapath strobes
//  Read,Write out  1   memory strobes
//  Gra,Grb,Grc,Rin,Rout,BAout  out 1  register-select strobes
//  alu_op     out  4   0=ADD 1=SUB 2=AND 3=OR; 0 whenever Zin=0
//  run        out  1   1 while executing; 0 in RESET and HALT
// BEHAVIOUR
//  - Clock and reset: one clock (clk). clr is asynchronous and active-high.
//    clr forces state=RESET at once. In RESET every output is 0, including run.
//  - RESET->T0 on the first edge after clr falls. clr mid-instruction abandons it; no strobe survives.
//  - Outputs are decoded only from the registered state and ir. They have no combinational path from
//    mem_ready. Any strobe not listed for a step is 0.
//  - Fetch steps:
//    T0: PCout MARin IncPC Zin (alu_op=ADD).
//    T1: Zlowout PCin Read MDRin. Held while mem_ready=0; PCin pulses only on the first T1 cycle.
//    T2: MDRout IRin.
//  - Opcode table: ld=00000 ldi=00001 st=00010 add=00011 sub=00100 and=00101 or=00110 addi=01100
//    andi=01101 ori=01110 nop=11010 halt=11011.
//  - Any other opcode is treated as nop: T3 has no strobes, then T0.
//  - add/sub/and/or:
//    T3: Grb Rout Yin.
//    T4: Grc Rout Zin alu_op.
//    T5: Zlowout Gra Rin, then T0.
//  - addi/andi/ori:
//    T3: Grb Rout Yin.
//    T4: Cout Zin alu_op (ADD/AND/OR).
//    T5: Zlowout Gra Rin, then T0.
//  - ldi:
//    T3: Grb BAout Yin.
//    T4: Cout Zin ADD.
//    T5: Zlowout Gra Rin, then T0.
//  - ld: T3-T4 as ldi.
//    T5: Zlowout MARin.
//    T6: Read MDRin, waits on mem_ready.
//    T7: MDRout Gra Rin, then T0.
//  - st: T3-T5 as ld.
//    T6: Gra Rout MDRin with Read=0 (MDR loads from bus).
//    T7: Write, waits on mem_ready; then T0.
//  - nop: T3 has no strobes, then T0. halt: T3->HALT.
//  - HALT: all outputs 0, run=0. Only clr exits it.
//  - Wait rule: in T1/T6(ld)/T7(st), stay in the step while mem_ready=0 and hold all strobes.
//    Advance on the edge where mem_ready=1. If mem_ready is high on the first cycle, the step lasts one cycle.
//  - Exactly one of Gra/Grb/Grc is high in any cycle where Rin, Rout or BAout is high.
//  - Rin and Rout are never both high.
//  - Cycle counts with mem_ready always 1:
//    ALU, imm, ldi = 6 cycles; ld, st = 8 cycles; nop = 4 cycles.
// TESTING
//  1. clr=1 then release, ir=add(00011) Ra=1 Rb=2 Rc=3, mem_ready=1 -> RESET, T0..T5 in 6 cycles;
//     T4 has Grc,Rout,Zin, alu_op=0; T5 has Gra,Rin.
//  2. ld, mem_ready low 3 cycles in both T1 and T6 -> Read/MDRin held 4 cycles each; T7 has MDRout Gra Rin;
//     14 cycles in total; PCin high once.
//  3. st, mem_ready low 2 cycles in T7 -> T6 has Gra Rout MDRin with Read=0; Write high 3 cycles; then T0 with PCout.
//  4. ir=sub, clr pulsed asynchronously during T4 -> all outputs 0 immediately;
//     T0 on the first edge after RESET; no Rin seen for the aborted instruction.
//  5. ir=halt -> after T3 run=0 and all strobes 0 for 20+ cycles; clr then release -> T0 strobes resume.
//  6. ir opcode 11111 and ir=nop -> T0 T1 T2 T3 T0; no Rin/Rout/Write asserted; alu_op=0 outside T0.

Source files
------------

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch T0-T2 and execute T3-T7. Datapath, memory and
// register-select strobes are decoded from the state register and the IR opcode.
module control_sequencer #(
  parameter int unsigned OPW = 5
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        IncPC,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Cout,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic [3:0]  alu_op,
  output logic        run
);

  localparam logic [3:0] S_RESET = 4'd0;
  localparam logic [3:0] S_T0    = 4'd1;
  localparam logic [3:0] S_T1    = 4'd2;
  localparam logic [3:0] S_T1W   = 4'd3;
  localparam logic [3:0] S_T2    = 4'd4;
  localparam logic [3:0] S_T3    = 4'd5;
  localparam logic [3:0] S_T4    = 4'd6;
  localparam logic [3:0] S_T5    = 4'd7;
  localparam logic [3:0] S_T6    = 4'd8;
  localparam logic [3:0] S_T7    = 4'd9;
  localparam logic [3:0] S_HALT  = 4'd10;

  localparam logic [OPW-1:0] OP_LD   = OPW'(5'b00000);
  localparam logic [OPW-1:0] OP_LDI  = OPW'(5'b00001);
  localparam logic [OPW-1:0] OP_ST   = OPW'(5'b00010);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
  localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01100);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(5'b01101);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(5'b01110);
  localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;

  logic [3:0]     r_state;
  logic [3:0]     w_state_next;
  logic [OPW-1:0] w_opcode;
  logic           w_unused_ir;
  logic           w_is_reg_alu;
  logic           w_is_imm;
  logic           w_is_ldi;
  logic           w_is_ld;
  logic           w_is_st;
  logic           w_is_halt;
  logic           w_is_mem;
  logic           w_uses_ba;
  logic [3:0]     w_alu_code;

  assign w_opcode    = ir[31 -: OPW];
  assign w_unused_ir = ^ir[31-OPW:0];

  // Opcode class decode; anything unlisted falls through as nop.
  always_comb begin
    w_is_reg_alu = 1'b0;
    w_is_imm     = 1'b0;
    w_is_ldi     = 1'b0;
    w_is_ld      = 1'b0;
    w_is_st      = 1'b0;
    w_is_halt    = 1'b0;
    w_alu_code   = ALU_ADD;
    case (w_opcode)
      OP_LD:   w_is_ld = 1'b1;
      OP_LDI:  w_is_ldi = 1'b1;
      OP_ST:   w_is_st = 1'b1;
      OP_ADD:  w_is_reg_alu = 1'b1;
      OP_SUB:  begin w_is_reg_alu = 1'b1; w_alu_code = ALU_SUB; end
      OP_AND:  begin w_is_reg_alu = 1'b1; w_alu_code = ALU_AND; end
      OP_OR:   begin w_is_reg_alu = 1'b1; w_alu_code = ALU_OR;  end
      OP_ADDI: w_is_imm = 1'b1;
      OP_ANDI: begin w_is_imm = 1'b1; w_alu_code = ALU_AND; end
      OP_ORI:  begin w_is_imm = 1'b1; w_alu_code = ALU_OR;  end
      OP_HALT: w_is_halt = 1'b1;
      default: ;
    endcase
  end

  assign w_is_mem  = w_is_ld | w_is_st;
  assign w_uses_ba = w_is_ldi | w_is_mem;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= S_RESET;
    else     r_state <= w_state_next;
  end

  assign run = (r_state != S_RESET) && (r_state != S_HALT);

  // Next-state and strobe decode; every strobe defaults low for each step.
  always_comb begin
    w_state_next = r_state;
    PCout   = 1'b0;
    IncPC   = 1'b0;
    PCin    = 1'b0;
    MARin   = 1'b0;
    MDRin   = 1'b0;
    MDRout  = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    Zin     = 1'b0;
    Zlowout = 1'b0;
    Cout    = 1'b0;
    Read    = 1'b0;
    Write   = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Grc     = 1'b0;
    Rin     = 1'b0;
    Rout    = 1'b0;
    BAout   = 1'b0;
    alu_op  = ALU_ADD;
    case (r_state)
      S_RESET: w_state_next = S_T0;
      S_T0: begin
        PCout        = 1'b1;
        MARin        = 1'b1;
        IncPC        = 1'b1;
        Zin          = 1'b1;
        alu_op       = ALU_ADD;
        w_state_next = S_T1;
      end
      // First fetch cycle loads PC; the wait state repeats T1 without PCin.
      S_T1, S_T1W: begin
        Zlowout      = 1'b1;
        PCin         = (r_state == S_T1);
        Read         = 1'b1;
        MDRin        = 1'b1;
        w_state_next = mem_ready ? S_T2 : S_T1W;
      end
      S_T2: begin
        MDRout       = 1'b1;
        IRin         = 1'b1;
        w_state_next = S_T3;
      end
      S_T3: begin
        if (w_is_reg_alu || w_is_imm) begin
          Grb          = 1'b1;
          Rout         = 1'b1;
          Yin          = 1'b1;
          w_state_next = S_T4;
        end else if (w_uses_ba) begin
          Grb          = 1'b1;
          BAout        = 1'b1;
          Yin          = 1'b1;
          w_state_next = S_T4;
        end else if (w_is_halt) begin
          w_state_next = S_HALT;
        end else begin
          w_state_next = S_T0;
        end
      end
      S_T4: begin
        if (w_is_reg_alu) begin
          Grc          = 1'b1;
          Rout         = 1'b1;
          Zin          = 1'b1;
          alu_op       = w_alu_code;
          w_state_next = S_T5;
        end else if (w_is_imm || w_uses_ba) begin
          Cout         = 1'b1;
          Zin          = 1'b1;
          alu_op       = w_alu_code;
          w_state_next = S_T5;
        end else begin
          w_state_next = S_T0;
        end
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (w_is_mem) begin
          MARin        = 1'b1;
          w_state_next = S_T6;
        end else begin
          Gra          = 1'b1;
          Rin          = 1'b1;
          w_state_next = S_T0;
        end
      end
      S_T6: begin
        if (w_is_ld) begin
          Read         = 1'b1;
          MDRin        = 1'b1;
          w_state_next = mem_ready ? S_T7 : S_T6;
        end else if (w_is_st) begin
          Gra          = 1'b1;
          Rout         = 1'b1;
          MDRin        = 1'b1;
          w_state_next = S_T7;
        end else begin
          w_state_next = S_T0;
        end
      end
      S_T7: begin
        if (w_is_ld) begin
          MDRout       = 1'b1;
          Gra          = 1'b1;
          Rin          = 1'b1;
          w_state_next = S_T0;
        end else if (w_is_st) begin
          Write        = 1'b1;
          w_state_next = mem_ready ? S_T0 : S_T7;
        end else begin
          w_state_next = S_T0;
        end
      end
      S_HALT:  w_state_next = S_HALT;
      default: w_state_next = S_RESET;
    endcase
  end

endmodule
